// File: rtl/button_pkg.sv
// Shared constants, state encoding and arbitration helpers for the button command controller.
package button_pkg;

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned CODE_W  = 3;

    localparam int unsigned BTN_RIGHT  = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_CENTER = 4;

    localparam logic [CODE_W-1:0] CMD_NONE   = 3'd0;
    localparam logic [CODE_W-1:0] CMD_RIGHT  = 3'd1;
    localparam logic [CODE_W-1:0] CMD_DOWN   = 3'd2;
    localparam logic [CODE_W-1:0] CMD_LEFT   = 3'd3;
    localparam logic [CODE_W-1:0] CMD_UP     = 3'd4;
    localparam logic [CODE_W-1:0] CMD_CENTER = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } state_e;

    // Highest-index set bit wins (center > up > left > down > right).
    function automatic logic [NUM_BTN-1:0] prio_onehot(input logic [NUM_BTN-1:0] rise);
        logic [NUM_BTN-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rise[i]) oh = NUM_BTN'(1) << i;
        end
        return oh;
    endfunction

    // Command code is button index plus one; zero input maps to CMD_NONE.
    function automatic logic [CODE_W-1:0] code_of(input logic [NUM_BTN-1:0] oh);
        logic [CODE_W-1:0] code;
        code = CMD_NONE;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (oh[i]) code = CODE_W'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/button_cmd_ctrl_if.sv
// Valid/ready command channel from the button controller to the PC/shifter control logic.
interface button_cmd_ctrl_if
    import button_pkg::*;
();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CODE_W-1:0] cmd_code;
    logic              cmd_repeat;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_repeat,
        output cmd_ready
    );
endinterface

// File: rtl/button_cmd_ctrl_hold_timer.sv
// Saturating wait counter; done flags the cycle in which the count reaches tc_i-1.
module hold_timer #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q;

    // Clear loads 1 because the accept cycle itself is the first elapsed cycle of the wait.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = CNT_W'(1);
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= (count_d == (tc_i - CNT_W'(1)));
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/button_cmd_ctrl.sv
// Arbitrates debounced button presses into single encoded commands with hold-to-repeat.
module button_cmd_ctrl
    import button_pkg::*;
#(
    parameter int unsigned        HOLD_CYCLES   = 50_000_000,
    parameter int unsigned        REPEAT_CYCLES = 10_000_000,
    parameter int unsigned        CNT_W         = 27,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK   = 5'b01111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTN-1:0]  btn_lvl,
    button_cmd_ctrl_if.master   cmd,
    output logic [NUM_BTN-1:0]  owner
);

    state_e             state_q;
    logic [NUM_BTN-1:0] prev_lvl_q;
    logic [NUM_BTN-1:0] owner_q;
    logic               valid_q;
    logic [CODE_W-1:0]  code_q;
    logic               repeat_q;

    logic [NUM_BTN-1:0] rise_c;
    logic [NUM_BTN-1:0] win_c;
    logic               owner_held_c;
    logic               repeat_en_c;
    logic               accept_c;
    logic               timer_clr_c;
    logic               timer_en_c;
    logic               timer_done_c;
    logic [CNT_W-1:0]   tc_c;

    assign rise_c       = btn_lvl & ~prev_lvl_q;
    assign win_c        = prio_onehot(rise_c);
    assign owner_held_c = |(btn_lvl & owner_q);
    assign repeat_en_c  = |(owner_q & REPEAT_MASK);
    assign accept_c     = valid_q & cmd.cmd_ready;
    assign timer_clr_c  = (state_q == ST_ISSUE) && accept_c;
    assign timer_en_c   = (state_q == ST_HOLD) || (state_q == ST_REPEAT);

    // At accept the upcoming wait is REPEAT if the command just accepted was itself a repeat.
    assign tc_c = ((state_q == ST_REPEAT) || ((state_q == ST_ISSUE) && repeat_q))
                  ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES);

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr_c),
        .en_i   (timer_en_c),
        .tc_i   (tc_c),
        .done_o (timer_done_c)
    );

    always_ff @(posedge clk) begin
        prev_lvl_q <= btn_lvl;
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            valid_q  <= 1'b0;
            code_q   <= CMD_NONE;
            repeat_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|rise_c) begin
                        owner_q  <= win_c;
                        valid_q  <= 1'b1;
                        code_q   <= code_of(win_c);
                        repeat_q <= 1'b0;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (valid_q) begin
                        if (cmd.cmd_ready) begin
                            valid_q <= 1'b0;
                            if (!owner_held_c) begin
                                state_q <= ST_IDLE;
                                owner_q <= '0;
                                code_q  <= CMD_NONE;
                            end else if (repeat_en_c) begin
                                state_q <= repeat_q ? ST_REPEAT : ST_HOLD;
                            end
                        end
                    end else if (!owner_held_c) begin
                        // Repeat disabled: parked here until the owner lets go.
                        state_q <= ST_IDLE;
                        owner_q <= '0;
                        code_q  <= CMD_NONE;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!owner_held_c) begin
                        state_q <= ST_IDLE;
                        owner_q <= '0;
                        code_q  <= CMD_NONE;
                    end else if (timer_done_c) begin
                        valid_q  <= 1'b1;
                        repeat_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= '0;
                    valid_q <= 1'b0;
                    code_q  <= CMD_NONE;
                end
            endcase
        end
    end

    assign cmd.cmd_valid  = valid_q;
    assign cmd.cmd_code   = code_q;
    assign cmd.cmd_repeat = repeat_q;
    assign owner          = owner_q;

endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Directed bench for button_cmd_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_cmd_ctrl;
    import button_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic [4:0] owner;
    int         total = 0;
    int         bad   = 0;
    int         nvalid;
    logic       expv;

    always #5 clk = ~clk;

    button_cmd_ctrl_if bus ();

    button_cmd_ctrl #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (4),
        .REPEAT_MASK   (5'b01111)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_lvl (btn),
        .cmd     (bus),
        .owner   (owner)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cmd(input string tag, input logic v, input logic [2:0] c, input logic r);
        chk({tag, "_valid"}, 32'(bus.cmd_valid), 32'(v));
        if (v) begin
            chk({tag, "_code"}, 32'(bus.cmd_code), 32'(c));
            chk({tag, "_repeat"}, 32'(bus.cmd_repeat), 32'(r));
        end
    endtask

    initial begin
        rst           = 1'b1;
        btn           = 5'b00000;
        bus.cmd_ready = 1'b1;
        tick(2);
        chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_code", 32'(bus.cmd_code), 32'd0);
        chk("rst_repeat", 32'(bus.cmd_repeat), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        tick(2);

        // Up press: one command, release ends it
        btn = 5'b01000;
        tick(1);
        chk_cmd("up_cmd", 1'b1, 3'd4, 1'b0);
        chk("up_owner", 32'(owner), 32'h08);
        tick(1);
        chk("up_after_accept", 32'(bus.cmd_valid), 32'd0);
        tick(1);
        btn = 5'b00000;
        tick(1);
        chk("up_rel_owner", 32'(owner), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("up_quiet", 32'(bus.cmd_valid), 32'd0);
        end

        // Simultaneous center+down+right: center only
        btn = 5'b10011;
        tick(1);
        chk_cmd("multi_cmd", 1'b1, 3'd5, 1'b0);
        chk("multi_owner", 32'(owner), 32'h10);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("multi_hold_quiet", 32'(bus.cmd_valid), 32'd0);
        end
        btn = 5'b00011;
        tick(1);
        chk("multi_rel_owner", 32'(owner), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("multi_rest_quiet", 32'(bus.cmd_valid), 32'd0);
        end
        btn = 5'b00000;
        tick(2);

        // Right held: initial at +1, repeats at +9, +13, +17
        btn = 5'b00001;
        for (int c = 1; c <= 18; c++) begin
            tick(1);
            expv = (c == 1) || (c == 9) || (c == 13) || (c == 17);
            chk_cmd($sformatf("rpt_c%0d", c), expv, 3'd1, (c != 1));
        end
        btn = 5'b00000;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("rpt_rel_valid", 32'(bus.cmd_valid), 32'd0);
            chk("rpt_rel_owner", 32'(owner), 32'd0);
        end

        // Left with backpressure: stable 6 cycles, accept on 7th, repeat 8 later
        bus.cmd_ready = 1'b0;
        btn = 5'b00100;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk_cmd($sformatf("bp_stall%0d", i), 1'b1, 3'd3, 1'b0);
        end
        tick(1);
        bus.cmd_ready = 1'b1;
        chk_cmd("bp_accept", 1'b1, 3'd3, 1'b0);
        for (int c = 8; c <= 15; c++) begin
            tick(1);
            chk_cmd($sformatf("bp_c%0d", c), (c == 15), 3'd3, 1'b1);
        end
        btn = 5'b00000;
        tick(1);
        chk("bp_rel_valid", 32'(bus.cmd_valid), 32'd0);
        chk("bp_rel_owner", 32'(owner), 32'd0);
        tick(2);

        // Center held: repeat disabled, exactly one command
        btn = 5'b10000;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.cmd_valid) nvalid++;
        end
        chk("center_count", 32'(nvalid), 32'd1);
        btn = 5'b00000;
        tick(2);

        // Down held through reset: silent until re-pressed
        btn = 5'b00010;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("rsthold_valid", 32'(bus.cmd_valid), 32'd0);
            chk("rsthold_owner", 32'(owner), 32'd0);
        end
        btn = 5'b00000;
        tick(1);
        btn = 5'b00010;
        tick(1);
        chk_cmd("repress_cmd", 1'b1, 3'd2, 1'b0);
        btn = 5'b00000;
        tick(3);

        // Reset while a command is pending drops it
        bus.cmd_ready = 1'b0;
        btn = 5'b01000;
        tick(1);
        chk_cmd("midrst_pend", 1'b1, 3'd4, 1'b0);
        rst = 1'b1;
        tick(1);
        chk("midrst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        bus.cmd_ready = 1'b1;
        btn = 5'b00000;
        tick(2);
        chk("midrst_quiet", 32'(bus.cmd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
